// File: rtl/nested_loop_walker.sv
// Two-level counted loop with inner/outer early breaks. Latency is min(inner_cnt,inner_brk)+2 cycles per outer iteration plus one DONE cycle.
// No backpressure: start is taken only in IDLE, and a start seen in any other state is dropped.
module nested_loop_walker #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    outer_cnt,
    input  logic [CW-1:0]    inner_cnt,
    input  logic [CW-1:0]    inner_brk,
    input  logic [15:0]      step,
    input  logic [WIDTH-1:0] a_limit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    typedef enum logic [1:0] {
        IDLE,
        INNER,
        OUTER_CHK,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cfg_outer;
    logic [CW-1:0]    cfg_inner;
    logic [CW-1:0]    cfg_brk;
    logic [WIDTH-1:0] cfg_step;
    logic [WIDTH-1:0] cfg_limit;
    logic [CW-1:0]    i;
    logic [CW-1:0]    j;

    logic inner_exit;
    logic outer_exit;

    // Both exits read registered values, so the a>=a_limit test uses a as it was on entry to OUTER_CHK.
    always_comb begin
        inner_exit = (j == cfg_inner) || (j == cfg_brk);
        outer_exit = (a >= cfg_limit) || ((i + CW'(1)) == cfg_outer);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (outer_cnt == '0) ? DONE : INNER;
                end
            end
            INNER: begin
                busy = 1'b1;
                if (inner_exit) begin
                    state_next = OUTER_CHK;
                end
            end
            OUTER_CHK: begin
                busy       = 1'b1;
                state_next = outer_exit ? DONE : INNER;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_outer <= '0;
            cfg_inner <= '0;
            cfg_brk   <= '0;
            cfg_step  <= '0;
            cfg_limit <= '0;
            i         <= '0;
            j         <= '0;
            a         <= '0;
            b         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_outer <= outer_cnt;
                        cfg_inner <= inner_cnt;
                        cfg_brk   <= inner_brk;
                        cfg_step  <= WIDTH'(step);
                        cfg_limit <= a_limit;
                        i         <= '0;
                        j         <= '0;
                        a         <= '0;
                        b         <= '0;
                    end
                end
                INNER: begin
                    if (!inner_exit) begin
                        a <= a + cfg_step;
                        j <= j + CW'(1);
                    end
                end
                OUTER_CHK: begin
                    b <= b + WIDTH'(1);
                    i <= i + CW'(1);
                    if (!outer_exit) begin
                        j <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nested_loop_walker.sv
// Directed runs on a 32-bit and a 16-bit walker; a monitor checks each done pulse against queued expectations.
module tb_nested_loop_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  outer_cnt, inner_cnt, inner_brk;
    logic [15:0] step;
    logic [31:0] a_limit;
    logic        busy, done;
    logic [31:0] a, b;

    logic        start16;
    logic [7:0]  outer16, inner16, brk16;
    logic [15:0] step16;
    logic [15:0] limit16;
    logic        busy16, done16;
    logic [15:0] a16, b16;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int overlap = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          st;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    nested_loop_walker #(.WIDTH(32), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .outer_cnt(outer_cnt),
        .inner_cnt(inner_cnt), .inner_brk(inner_brk), .step(step),
        .a_limit(a_limit), .busy(busy), .done(done), .a(a), .b(b)
    );

    nested_loop_walker #(.WIDTH(16), .CW(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .outer_cnt(outer16),
        .inner_cnt(inner16), .inner_brk(brk16), .step(step16),
        .a_limit(limit16), .busy(busy16), .done(done16), .a(a16), .b(b16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy && done) overlap++;
        if (busy16 && done16) overlap++;
        if (done) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                check("a32", a, e.a);
                check("b32", b, e.b);
                check("lat32", 32'(cyc - e.st), 32'(e.lat));
            end
        end
        if (done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check("a16", {16'd0, a16}, e.a);
                check("b16", {16'd0, b16}, e.b);
                check("lat16", 32'(cyc - e.st), 32'(e.lat));
            end
        end
    end

    // Issues one start and queues the expected result; afterwards the inputs are scrambled so
    // only the latched configuration can matter.
    task automatic start32(input int o, input int in, input int bk, input int st,
                           input logic [31:0] lim, input logic [31:0] ea,
                           input logic [31:0] eb, input int lat);
        exp_t e;
        @(negedge clk);
        outer_cnt = 8'(o); inner_cnt = 8'(in); inner_brk = 8'(bk);
        step = 16'(st); a_limit = lim; start = 1'b1;
        e.a = ea; e.b = eb; e.lat = lat; e.st = cyc;
        q32.push_back(e);
        @(negedge clk);
        start = 1'b0;
        outer_cnt = 8'($urandom); inner_cnt = 8'($urandom); inner_brk = 8'($urandom);
        step = 16'($urandom); a_limit = $urandom;
    endtask

    task automatic wait_done32(input int budget, output bit busy_seen);
        bit seen = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            busy_seen |= busy;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done32_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit bs;
        exp_t e;
        int done_cnt;
        rst = 1'b1; start = 1'b0; start16 = 1'b0;
        outer_cnt = '0; inner_cnt = '0; inner_brk = '0; step = '0; a_limit = '0;
        outer16 = '0; inner16 = '0; brk16 = '0; step16 = '0; limit16 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_a", a, 32'd0);
        check("rst_b", b, 32'd0);
        rst = 1'b0;

        // Full run; a start held during the DONE cycle must be dropped.
        start32(10, 20, 11, 1, 1000, 110, 10, 131);
        wait_done32(300, bs);
        start = 1'b1; outer_cnt = 8'd1; inner_cnt = 8'd1; inner_brk = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        check("hold_a", a, 32'd110);
        check("hold_b", b, 32'd10);
        @(negedge clk);
        check("still_idle", {31'd0, busy}, 32'd0);

        start32(10, 20, 11, 1, 50, 55, 5, 66);
        wait_done32(300, bs);

        start32(0, 20, 11, 1, 1000, 0, 0, 1);
        wait_done32(10, bs);
        check("outer0_busy_never", {31'd0, bs}, 32'd0);

        start32(4, 0, 5, 7, 1000, 0, 4, 9);
        wait_done32(50, bs);
        start32(3, 6, 0, 7, 1000, 0, 3, 7);
        wait_done32(50, bs);
        start32(5, 3, 9, 2, 0, 6, 1, 6);
        wait_done32(50, bs);

        // A start pulsed mid-run with a different configuration must not disturb the run.
        start32(10, 20, 11, 1, 1000, 110, 10, 131);
        repeat (30) @(negedge clk);
        start = 1'b1; outer_cnt = 8'd1; inner_cnt = 8'd2; inner_brk = 8'd2;
        @(negedge clk);
        start = 1'b0;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        wait_done32(300, bs);

        // Abort by reset 20 cycles into a run: no done pulse may follow.
        start32(10, 20, 11, 1, 1000, 110, 10, 131);
        e = q32.pop_back();
        while (cyc < e.st + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_a", a, 32'd0);
        check("abort_b", b, 32'd0);
        done_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        start32(10, 20, 11, 1, 1000, 110, 10, 131);
        wait_done32(300, bs);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; outer_cnt = 8'd2; inner_cnt = 8'd2; inner_brk = 8'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_over_start", {31'd0, busy}, 32'd0);

        // 16-bit instance: inner_cnt governs and a wraps.
        @(negedge clk);
        outer16 = 8'd3; inner16 = 8'd4; brk16 = 8'd200; step16 = 16'hFFFF;
        limit16 = 16'hFFFF; start16 = 1'b1;
        e.a = 32'h0000_FFF4; e.b = 32'd3; e.lat = 19; e.st = cyc;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0; outer16 = 8'd9; inner16 = 8'd9;
        begin
            bit seen16 = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (done16) begin
                    seen16 = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen16) check("done16_timeout", 32'd0, 32'd1);
        end

        repeat (3) @(negedge clk);
        check("q32_drained", 32'(q32.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        check("busy_done_overlap", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nested_loop_walker.md
NESTED_LOOP_WALKER -- requirements
Module: nested_loop_walker

Interface
REQ-001 Parameter: WIDTH, default 32, width of the accumulators, a_limit and the result outputs.
REQ-002 Parameter: CW, default 8, width of the loop-count and break-index inputs and the internal indices.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  request a run; sampled only in IDLE.
REQ-006 Port: outer_cnt  input  CW  outer loop trip count.
REQ-007 Port: inner_cnt  input  CW  inner loop trip count.
REQ-008 Port: inner_brk  input  CW  inner index at which the inner loop breaks.
REQ-009 Port: step  input  16  amount added to a per inner iteration, zero-extended to WIDTH.
REQ-010 Port: a_limit  input  WIDTH  outer-break threshold on a.
REQ-011 Port: busy  output  1  high in INNER and OUTER_CHK.
REQ-012 Port: done  output  1  one-cycle pulse in DONE.
REQ-013 Port: a  output  WIDTH  inner-iteration accumulator.
REQ-014 Port: b  output  WIDTH  count of completed outer iterations.

Function
REQ-015 The FSM SHALL have four states: IDLE, INNER, OUTER_CHK, DONE.
REQ-016 In IDLE with start=1, the block SHALL latch all configuration inputs, clear a, b, i and j, and go to INNER; if outer_cnt=0 it SHALL go to DONE instead.
REQ-017 Configuration inputs changing after acceptance SHALL have no effect until the next accepted start.
REQ-018 In INNER, if j==inner_cnt or j==inner_brk, the FSM SHALL go to OUTER_CHK with no accumulation that cycle.
REQ-019 Otherwise, in INNER, a SHALL take a+step and j SHALL take j+1.
REQ-020 In OUTER_CHK, b SHALL take b+1 and i SHALL take i+1.
REQ-021 In OUTER_CHK, if a>=a_limit (unsigned, using the value at entry) or i+1==outer_cnt, the FSM SHALL go to DONE; otherwise it SHALL clear j and return to INNER.
REQ-022 Each outer iteration SHALL take exactly min(inner_cnt,inner_brk)+2 cycles.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 a and b SHALL hold their final values in IDLE until the next accepted start.
REQ-025 A start asserted while not in IDLE, including in DONE, SHALL be ignored and not queued.
REQ-026 a SHALL wrap modulo 2^WIDTH, with no saturation or flag.
REQ-027 inner_cnt=0 or inner_brk=0 SHALL yield outer iterations with zero accumulation that still increment b.
REQ-028 busy and done SHALL never be high in the same cycle.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, a, b, i and j SHALL all be 0, regardless of state.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 Reset during a run SHALL abort it with no done pulse.

Verification
REQ-032 outer=10, inner=20, brk=11, step=1, a_limit=1000 -> done exactly 131 cycles after the start cycle; a=110, b=10.
REQ-033 Same configuration with a_limit=50 -> early outer break; a=55, b=5; done 66 cycles after start.
REQ-034 outer=0 -> done on the cycle after start; busy never high; a=0, b=0.
REQ-035 outer=3, inner=4, brk=200, step=0xFFFF, WIDTH=16 -> inner_cnt governs; a wraps to 0xFFF4, b=3.
REQ-036 Run with outer=10, inner=20, brk=11, step=1, a_limit=1000; pulse start mid-run; then, in a separate run, assert rst at cycle 20 -> the mid-run start is ignored, and the reset aborts the run with no done pulse, all outputs 0 next cycle, and a fresh start then completes normally.
